shift_right_seq: RTL and testbench
==================================

# shift_right_seq

Multi-cycle logical/arithmetic right shifter for the LEGv8 execute stage, servicing LSR and ASR-style operations. It is the right-shift counterpart to the fixed left-shift path used for branch offsets. It accepts one operand and a shift amount per START handshake, shifts iteratively by up to STEP bits per cycle, and then presents a registered result with a one-cycle DONE pulse. The control unit stalls the pipeline while BUSY is high.

## Interface
- WIDTH, 64: operand/result width in bits.
- STEP, 8: maximum shift distance per iteration cycle; must be a power of two with 1 ≤ STEP ≤ WIDTH.
- CLK  in  1  rising-edge clock; one clock domain.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled on rising CLK edges and accepted only in IDLE or DONE state.
- OP_ASR  in  1  0 = logical shift right (zero fill); 1 = arithmetic shift right (fill with DATA_IN[WIDTH-1]).
- DATA_IN  in  WIDTH  operand; captured on the accepting edge.
- SHAMT  in  $clog2(WIDTH)  shift amount, 0..WIDTH-1; captured on the accepting edge.
- BUSY  out  1  high while in SHIFT state.
- DONE  out  1  one-cycle pulse; high exactly while in DONE state.
- SHIFT_OUT  out  WIDTH  result register; holds its value until the next DONE.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- Accepting edge, when START=1 in IDLE or DONE:
  - Load the working register with DATA_IN.
  - Load the remaining count REM with SHAMT.
  - Latch OP_ASR and latch the fill bit: OP_ASR ? DATA_IN[WIDTH-1] : 0.
  - Next state: SHIFT if SHAMT≠0; DONE if SHAMT=0. For SHAMT=0, SHIFT_OUT <= DATA_IN on the same edge.
- SHIFT: on each edge:
  - Let d = min(REM, STEP). Shift the working register right by d, filling the vacated MSBs with the latched fill bit.
  - REM <= REM − d.
  - When REM − d = 0: SHIFT_OUT <= the shifted value and next state is DONE.
- DONE: lasts exactly one cycle.
  - Next state: SHIFT or DONE if START=1 with a new request accepted (back-to-back operation); IDLE otherwise.
- START in SHIFT state is ignored; nothing is queued.
- Values on DATA_IN, SHAMT and OP_ASR outside the accepting edge have no effect.
- SHIFT_OUT changes only on an edge that enters DONE. It never exposes partial results.
- Arithmetic: the result equals DATA_IN >> SHAMT for LSR and $signed(DATA_IN) >>> SHAMT for ASR, bit-exact for all SHAMT in 0..WIDTH-1.

## Timing
- Reset (RST_N=0, asynchronous, any state including mid-SHIFT):
  - State = IDLE, BUSY=0, DONE=0, SHIFT_OUT=0, REM=0.
  - The in-flight operation is discarded. The first accepting edge after reset release behaves normally.
- Latency: with N = ceil(SHAMT/STEP), DONE is high in the cycle following accepting edge + N edges.
  - SHAMT=0: DONE in the cycle right after the accepting edge.
  - SHAMT=63 with STEP=8: N=8.
- BUSY is high for exactly N cycles: the cycles after accepting edge +0 .. +N−1. BUSY=0 in IDLE and DONE.
- Throughput: one operation per N+1 cycles using back-to-back START in the DONE cycle.
- DONE and BUSY are never high simultaneously.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- LSR 0xF000_0000_0000_0000 by 63 → BUSY for 8 cycles, then DONE pulse, SHIFT_OUT=0x0000_0000_0000_0001. The same operand with ASR → 0xFFFF_FFFF_FFFF_FFFF.
- SHAMT=0, DATA_IN=0x1234, LSR → BUSY never asserts, DONE in the next cycle, SHIFT_OUT=0x1234.
- LSR 0x0000_0000_0000_FF00 by 9 → N=2 (shift 8, then 1), SHIFT_OUT=0x7F. ASR 0x7FFF_FFFF_FFFF_FFFF by 4 → N=1, SHIFT_OUT=0x07FF_FFFF_FFFF_FFFF.
- START with LSR 0xFF by 4 held through BUSY, with DATA_IN changed mid-operation:
  - Extra STARTs during BUSY are ignored; result=0xF.
  - START asserted in the DONE cycle with ASR 0x8000_0000_0000_0000 by 1 is accepted → next result 0xC000_0000_0000_0000 after 1 BUSY cycle.
- RST_N pulsed low during SHIFT of a 63-bit shift → BUSY, DONE and SHIFT_OUT are 0 immediately. No DONE follows. A new LSR 0x10 by 4 after release → SHIFT_OUT=0x1.
- Randomized sweep over all SHAMT 0..63 × both ops against the reference model, with latency checked as ceil(SHAMT/8).

Source files
------------

// File: rtl/shift_right_seq_if.sv
// Request/response bundle for the multi-cycle right shifter.
// The master drives the request and the slave returns status and result.
interface shift_right_seq_if #(
    parameter int unsigned WIDTH = 64
) ();
    localparam int unsigned SW = $clog2(WIDTH);

    logic             START;
    logic             OP_ASR;
    logic [WIDTH-1:0] DATA_IN;
    logic [SW-1:0]    SHAMT;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SHIFT_OUT;

    modport master (
        output START, OP_ASR, DATA_IN, SHAMT,
        input  BUSY, DONE, SHIFT_OUT
    );

    modport slave (
        input  START, OP_ASR, DATA_IN, SHAMT,
        output BUSY, DONE, SHIFT_OUT
    );
endinterface

// File: rtl/shift_right_seq.sv
// Iterative LSR/ASR unit: shifts up to STEP bits per cycle.
// The result register is updated only on the edge that enters DONE.
module shift_right_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned STEP  = 8
) (
    input logic              CLK,
    input logic              RST_N,
    shift_right_seq_if.slave bus
);
    localparam int unsigned SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SW-1:0]    rem_q, rem_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [SW-1:0]    step_amt;
    logic [WIDTH-1:0] shifted;
    logic             accept;

    always_comb begin
        // Step is min(REM, STEP); widened compare keeps STEP == WIDTH safe.
        if ({1'b0, rem_q} > (SW + 1)'(STEP)) begin
            step_amt = SW'(STEP);
        end else begin
            step_amt = rem_q;
        end
        shifted = (work_q >> step_amt) | ({WIDTH{fill_q}} & ~(ONES >> step_amt));
        accept  = bus.START && (state_q != S_SHIFT);
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        out_d   = out_q;
        unique case (state_q)
            S_SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step_amt;
                if (rem_q == step_amt) begin
                    out_d   = shifted;
                    state_d = S_DONE;
                end
            end
            default: begin
                if (accept) begin
                    work_d = bus.DATA_IN;
                    rem_d  = bus.SHAMT;
                    fill_d = bus.OP_ASR & bus.DATA_IN[WIDTH-1];
                    if (bus.SHAMT == '0) begin
                        out_d   = bus.DATA_IN;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
        end
    end

    assign bus.BUSY      = (state_q == S_SHIFT);
    assign bus.DONE      = (state_q == S_DONE);
    assign bus.SHIFT_OUT = out_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed cases plus a randomized
// sweep of every shift amount for both ops against an arithmetic reference.
module tb_shift_right_seq;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned STEP  = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [WIDTH-1:0] last_out;

    shift_right_seq_if #(.WIDTH(WIDTH)) bus ();

    shift_right_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                            input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_shift(input logic asr,
                                                   input logic [WIDTH-1:0] data,
                                                   input int unsigned sh);
        if (asr) return WIDTH'($signed(data) >>> sh);
        return data >> sh;
    endfunction

    // One full operation: drive at negedge, watch BUSY cycles, then check DONE.
    task automatic do_op(input logic asr, input logic [WIDTH-1:0] data,
                         input int unsigned sh, input string tag);
        logic [WIDTH-1:0] exp;
        int unsigned n_exp;
        int unsigned busy_cnt;
        bit          seen_done;
        exp   = ref_shift(asr, data, sh);
        n_exp = (sh + STEP - 1) / STEP;
        @(negedge clk);
        bus.START   = 1'b1;
        bus.OP_ASR  = asr;
        bus.DATA_IN = data;
        bus.SHAMT   = 6'(sh);
        @(negedge clk);
        bus.START   = 1'b0;
        bus.DATA_IN = {$urandom, $urandom};
        bus.SHAMT   = 6'($urandom);
        bus.OP_ASR  = 1'($urandom);
        busy_cnt  = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.DONE) begin
                seen_done = 1'b1;
                break;
            end
            if (bus.BUSY) busy_cnt++;
            check_eq({tag, "_hold"}, bus.SHIFT_OUT, last_out);
            @(negedge clk);
        end
        check_eq({tag, "_done_seen"}, 64'(seen_done), 64'd1);
        check_eq({tag, "_latency"}, 64'(busy_cnt), 64'(n_exp));
        check_eq({tag, "_busy_in_done"}, 64'(bus.BUSY), 64'd0);
        check_eq({tag, "_result"}, bus.SHIFT_OUT, exp);
        last_out = exp;
    endtask

    initial begin
        int unsigned done_cnt;
        errors = 0;
        checks = 0;
        last_out = '0;
        rst_n = 1'b0;
        bus.START = 1'b0;
        bus.OP_ASR = 1'b0;
        bus.DATA_IN = '0;
        bus.SHAMT = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(bus.BUSY), 64'd0);
        check_eq("rst_done", 64'(bus.DONE), 64'd0);
        check_eq("rst_out", bus.SHIFT_OUT, 64'd0);
        rst_n = 1'b1;

        do_op(1'b0, 64'hF000_0000_0000_0000, 63, "lsr63");
        do_op(1'b1, 64'hF000_0000_0000_0000, 63, "asr63");
        do_op(1'b0, 64'h1234, 0, "sh0");
        do_op(1'b0, 64'hFF00, 9, "lsr9");
        do_op(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4, "asr4");

        // START held through BUSY, then a back-to-back request in the DONE cycle.
        @(negedge clk);
        bus.START = 1'b1; bus.OP_ASR = 1'b0; bus.DATA_IN = 64'hFF; bus.SHAMT = 6'd4;
        @(negedge clk);
        check_eq("b2b_busy", 64'(bus.BUSY), 64'd1);
        bus.DATA_IN = 64'hDEAD_BEEF_0000_1111; bus.SHAMT = 6'd33; bus.OP_ASR = 1'b1;
        @(negedge clk);
        check_eq("b2b_done1", 64'(bus.DONE), 64'd1);
        check_eq("b2b_res1", bus.SHIFT_OUT, 64'hF);
        bus.OP_ASR = 1'b1; bus.DATA_IN = 64'h8000_0000_0000_0000; bus.SHAMT = 6'd1;
        @(negedge clk);
        bus.START = 1'b0;
        check_eq("b2b_busy2", 64'(bus.BUSY), 64'd1);
        check_eq("b2b_hold2", bus.SHIFT_OUT, 64'hF);
        @(negedge clk);
        check_eq("b2b_done2", 64'(bus.DONE), 64'd1);
        check_eq("b2b_res2", bus.SHIFT_OUT, 64'hC000_0000_0000_0000);
        @(negedge clk);
        check_eq("b2b_idle", 64'(bus.DONE), 64'd0);
        last_out = 64'hC000_0000_0000_0000;

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        bus.START = 1'b1; bus.OP_ASR = 1'b0; bus.DATA_IN = 64'hF000_0000_0000_0000; bus.SHAMT = 6'd63;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid_busy", 64'(bus.BUSY), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(bus.BUSY), 64'd0);
        check_eq("arst_done", 64'(bus.DONE), 64'd0);
        check_eq("arst_out", bus.SHIFT_OUT, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.DONE || bus.BUSY) done_cnt++;
        end
        check_eq("arst_quiet", 64'(done_cnt), 64'd0);
        last_out = '0;
        do_op(1'b0, 64'h10, 4, "post_rst");

        for (int unsigned sh = 0; sh < WIDTH; sh++) begin
            for (int unsigned op = 0; op < 2; op++) begin
                do_op(1'(op), {$urandom, $urandom}, sh, "sweep");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
